// File: rtl/add_round_key.sv
// AES-128 AddRoundKey stage with on-the-fly round key generation.
// Forward schedule for encryption, inverse schedule for decryption.
module add_round_key #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key,
    input  logic         key_load,
    output logic         key_ready,
    input  logic [127:0] in,
    input  logic         ready,
    input  logic         encrypt,
    output logic [127:0] out,
    output logic         done,
    output logic [3:0]   round
);

    typedef enum logic [1:0] {IDLE, EXPAND, RUN} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // One key-schedule step; the S-box input is w3 going forward, w3^w2 going back.
    function automatic logic [127:0] sched(
        input logic [127:0] k,
        input logic         inv,
        input logic [7:0]   rc
    );
        logic [31:0] w0, w1, w2, w3, p3, s, t, n0, n1, n2;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        p3 = w3 ^ w2;
        s  = inv ? p3 : w3;
        t  = {sbox(s[23:16]), sbox(s[15:8]), sbox(s[7:0]), sbox(s[31:24])}
             ^ {rc, 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        return inv ? {w0 ^ t, w1 ^ w0, w2 ^ w1, p3} : {n0, n1, n2, w3 ^ n2};
    endfunction

    state_t       state_q, state_d;
    logic [3:0]   step_q, step_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] ck_q, ck_d;
    logic [127:0] cur_q, cur_d;
    logic [127:0] last_q, last_d;
    logic         mode_q, mode_d;
    logic [127:0] out_q, out_d;
    logic         done_q, done_d;

    logic         round0;
    logic         eff_enc;
    logic [127:0] start_key;
    logic [127:0] kcur;
    logic [127:0] sched_in;
    logic [127:0] sched_out;
    logic         sched_inv;
    logic [3:0]   rc_idx;

    // At round 0 the live encrypt input picks the start key and direction.
    assign round0    = (round_q == 4'd0);
    assign eff_enc   = round0 ? encrypt : mode_q;
    assign start_key = encrypt ? ck_q : last_q;
    assign kcur      = round0 ? start_key : cur_q;
    assign sched_in  = (state_q == RUN) ? kcur : cur_q;
    assign sched_inv = (state_q == RUN) && !eff_enc;
    assign rc_idx    = (state_q == EXPAND) ? step_q
                     : eff_enc ? round_q + 4'd1
                     : 4'(NR) - round_q;
    assign sched_out = sched(sched_in, sched_inv, rcon(rc_idx));

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        round_d = round_q;
        ck_d    = ck_q;
        cur_d   = cur_q;
        last_d  = last_q;
        mode_d  = mode_q;
        out_d   = out_q;
        done_d  = 1'b0;
        if (key_load) begin
            ck_d    = key;
            cur_d   = key;
            step_d  = 4'd1;
            round_d = 4'd0;
            state_d = EXPAND;
        end else begin
            unique case (state_q)
                IDLE: ;
                EXPAND: begin
                    if (step_q != 4'(NR + 1)) begin
                        cur_d  = sched_out;
                        step_d = step_q + 4'd1;
                    end else begin
                        last_d  = cur_q;
                        cur_d   = encrypt ? ck_q : cur_q;
                        mode_d  = encrypt;
                        round_d = 4'd0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (ready) begin
                        out_d  = in ^ kcur;
                        done_d = 1'b1;
                        if (round_q != 4'(NR)) begin
                            round_d = round_q + 4'd1;
                            cur_d   = sched_out;
                            mode_d  = eff_enc;
                        end else begin
                            round_d = 4'd0;
                            cur_d   = mode_q ? ck_q : last_q;
                        end
                    end else if (round0 && encrypt != mode_q) begin
                        cur_d  = start_key;
                        mode_d = encrypt;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= 4'd0;
            round_q <= 4'd0;
            ck_q    <= '0;
            cur_q   <= '0;
            last_q  <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            round_q <= round_d;
            ck_q    <= ck_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign key_ready = (state_q == RUN);
    assign out       = out_q;
    assign done      = done_q;
    assign round     = round_q;

endmodule
